// File: rtl/hsync_decoder_pkg.sv
// Shared horizontal video timing defaults and decoder FSM states.
// Constants only: no latency, no flow control.
// Used by both the timing generator and its receive-side decoder.
package hsync_decoder_pkg;

    localparam int CNT_W  = 11;
    localparam int LINE_W = 4;

    localparam logic [CNT_W-1:0]  DEF_H_TOTAL    = 11'd1090;
    localparam logic [CNT_W-1:0]  DEF_SYNC_START = 11'd16;
    localparam logic [CNT_W-1:0]  DEF_SYNC_WIDTH = 11'd113;
    localparam logic [CNT_W-1:0]  DEF_TOL        = 11'd2;
    localparam logic [LINE_W-1:0] DEF_LOCK_LINES = 4'd3;
    localparam logic [LINE_W-1:0] DEF_MISS_LINES = 4'd2;
    localparam logic [CNT_W-1:0]  CNT_MAX        = 11'h7FF;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCK    = 2'd2
    } state_t;

    function automatic logic in_tol(input logic [CNT_W-1:0] val,
                                    input logic [CNT_W-1:0] nom,
                                    input logic [CNT_W-1:0] tol);
        return (val >= nom - tol) && (val <= nom + tol);
    endfunction

endpackage

// File: rtl/hsync_decoder_sync_edge_det.sv
// Sync-input conditioning: optional 2FF synchronizer (HSYNC_DEC_SYNC2FF_EN) plus edge detect.
// Latency: fe/re combinational off the previous-value register (+2 cycles with the synchronizer).
// No backpressure: one sample per clock, always accepted.
module sync_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic sync_in,
    output logic sync_lvl,
    output logic fe,
    output logic re
);

    logic sync_s;
    logic prev;

`ifdef HSYNC_DEC_SYNC2FF_EN
    logic meta;

    // Reset to the idle (high) level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta   <= 1'b1;
            sync_s <= 1'b1;
        end else begin
            meta   <= sync_in;
            sync_s <= meta;
        end
    end
`else
    assign sync_s = sync_in;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev <= 1'b1;
        end else begin
            prev <= sync_s;
        end
    end

    assign sync_lvl = sync_s;
    assign fe       = !sync_s && prev;
    assign re       = sync_s && !prev;

endmodule

// File: rtl/hsync_decoder.sv
// Recovers the horizontal pixel counter from an active-low hsync and tracks lock (HSYNC_DEC_SYNC2FF_EN adds a synchronizer).
// Latency: CNT aligned with zero lag to the generator; LINE_STB/ERR/LOCKED registered, one cycle after the event.
// No backpressure: free-running, every input sample is consumed.
module hsync_decoder
    import hsync_decoder_pkg::*;
#(
    parameter logic [CNT_W-1:0]  H_TOTAL    = DEF_H_TOTAL,
    parameter logic [CNT_W-1:0]  SYNC_START = DEF_SYNC_START,
    parameter logic [CNT_W-1:0]  SYNC_WIDTH = DEF_SYNC_WIDTH,
    parameter logic [CNT_W-1:0]  TOL        = DEF_TOL,
    parameter logic [LINE_W-1:0] LOCK_LINES = DEF_LOCK_LINES,
    parameter logic [LINE_W-1:0] MISS_LINES = DEF_MISS_LINES
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             SYNC_IN,
    output logic [CNT_W-1:0] CNT,
    output logic             LOCKED,
    output logic             LINE_STB,
    output logic [CNT_W-1:0] PERIOD,
    output logic             ERR
);

`ifdef HSYNC_DEC_SYNC2FF_EN
    localparam logic [CNT_W-1:0] LOAD_VAL = SYNC_START + 11'd3;
`else
    localparam logic [CNT_W-1:0] LOAD_VAL = SYNC_START + 11'd1;
`endif
    localparam logic [CNT_W-1:0] TMO_VAL  = H_TOTAL + TOL + 11'd1;

    logic sync_lvl;
    logic fe;
    logic re;

    state_t            state, state_nxt;
    logic [LINE_W-1:0] good_cnt, good_nxt;
    logic [LINE_W-1:0] miss_cnt, miss_nxt;
    logic [CNT_W-1:0]  pcnt;
    logic [CNT_W-1:0]  wcnt;
    logic              line_open;
    logic              period_ok;
    logic              tmo_pend;

    logic fe_in_tol;
    logic timeout;
    logic verdict_vld;
    logic verdict_good;
    logic accept;
    logic open_bad;
    logic err_evt;

    sync_edge_det u_edge (
        .clk      (CLK),
        .rstn     (RSTN),
        .sync_in  (SYNC_IN),
        .sync_lvl (sync_lvl),
        .fe       (fe),
        .re       (re)
    );

    assign fe_in_tol    = in_tol(pcnt, H_TOTAL, TOL);
    assign timeout      = (pcnt == TMO_VAL) && !fe;
    assign verdict_vld  = re && line_open;
    assign verdict_good = period_ok && in_tol(wcnt, SYNC_WIDTH, TOL);

    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        miss_nxt  = miss_cnt;
        accept    = 1'b0;
        open_bad  = 1'b0;
        err_evt   = 1'b0;
        case (state)
            SEARCH: begin
                if (fe) begin
                    state_nxt = ACQUIRE;
                    accept    = 1'b1;
                    good_nxt  = '0;
                    miss_nxt  = '0;
                end
            end
            ACQUIRE: begin
                accept = fe;
                if (timeout) begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end else if (verdict_vld) begin
                    if (!verdict_good) begin
                        good_nxt = '0;
                    end else if (good_cnt + 4'd1 >= LOCK_LINES) begin
                        state_nxt = LOCK;
                        good_nxt  = '0;
                        miss_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + 4'd1;
                    end
                end
            end
            LOCK: begin
                // A late edge right after a timeout belongs to the line the
                // timeout already condemned, so it must not be judged twice.
                if (fe) begin
                    accept   = fe_in_tol;
                    open_bad = !fe_in_tol && !tmo_pend;
                end
                if (timeout || (verdict_vld && !verdict_good)) begin
                    err_evt = 1'b1;
                    if (miss_cnt + 4'd1 >= MISS_LINES) begin
                        state_nxt = SEARCH;
                        miss_nxt  = '0;
                        good_nxt  = '0;
                    end else begin
                        miss_nxt = miss_cnt + 4'd1;
                    end
                end else if (verdict_vld) begin
                    miss_nxt = '0;
                end
            end
            default: begin
                state_nxt = SEARCH;
                good_nxt  = '0;
                miss_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state    <= SEARCH;
            good_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            miss_cnt <= miss_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            CNT       <= '0;
            LOCKED    <= 1'b0;
            LINE_STB  <= 1'b0;
            PERIOD    <= '0;
            ERR       <= 1'b0;
            pcnt      <= '0;
            wcnt      <= '0;
            line_open <= 1'b0;
            period_ok <= 1'b0;
            tmo_pend  <= 1'b0;
        end else begin
            if (accept) begin
                CNT <= LOAD_VAL;
            end else if (CNT == H_TOTAL - 11'd1) begin
                CNT <= '0;
            end else begin
                CNT <= CNT + 11'd1;
            end

            LOCKED   <= (state_nxt == LOCK);
            LINE_STB <= accept;
            ERR      <= err_evt;

            // Timeout reload places a virtual edge at the nominal position.
            if (fe) begin
                pcnt   <= 11'd1;
                PERIOD <= pcnt;
            end else if (timeout) begin
                pcnt <= TOL + 11'd1;
            end else if (pcnt != CNT_MAX) begin
                pcnt <= pcnt + 11'd1;
            end

            if (sync_lvl) begin
                wcnt <= '0;
            end else if (wcnt != CNT_MAX) begin
                wcnt <= wcnt + 11'd1;
            end

            if (accept || open_bad) begin
                line_open <= 1'b1;
                period_ok <= accept && fe_in_tol;
            end else if (re || timeout) begin
                line_open <= 1'b0;
            end

            if (fe) begin
                tmo_pend <= 1'b0;
            end else if (timeout) begin
                tmo_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hsync_decoder.sv
// Line-by-line loopback bench: drives generator lines from a table and scores per-line outcomes.
module tb_hsync_decoder;
    import hsync_decoder_pkg::*;

`ifdef HSYNC_DEC_SYNC2FF_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif
    // Sync rises at generator count 129; LOCKED follows one cycle later.
    localparam int RISE = 130 + DLY;
    localparam int SS   = int'(DEF_SYNC_START);

    typedef struct {
        int per;
        int wid;
        int rst_at;
        int stb;
        int err;
        int lock_end;   // 2 = don't care
        int rise;       // -1 = don't care, 0 = no rise in this line
        int match;
        int period;     // 0 = not checked
    } line_t;

    typedef struct {
        int stb;
        int err;
        int lock_end;
        int rise;
        int mis;
        int period;
    } res_t;

    logic             CLK = 1'b0;
    logic             RSTN = 1'b0;
    logic             SYNC_IN = 1'b1;
    logic [CNT_W-1:0] CNT;
    logic             LOCKED;
    logic             LINE_STB;
    logic [CNT_W-1:0] PERIOD;
    logic             ERR;

    int    n_tests = 0;
    int    n_fail  = 0;
    logic  lock_q  = 1'b0;
    line_t tbl[$];
    line_t exp_q[$];

    hsync_decoder dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .SYNC_IN  (SYNC_IN),
        .CNT      (CNT),
        .LOCKED   (LOCKED),
        .LINE_STB (LINE_STB),
        .PERIOD   (PERIOD),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic add(input int per, input int wid, input int rst_at, input int stb,
                       input int err, input int lock_end, input int rise,
                       input int match, input int period);
        line_t t;
        t.per = per; t.wid = wid; t.rst_at = rst_at; t.stb = stb; t.err = err;
        t.lock_end = lock_end; t.rise = rise; t.match = match; t.period = period;
        tbl.push_back(t);
    endtask

    task automatic run_line(input line_t t, input int idx, output res_t r);
        r.stb = 0; r.err = 0; r.mis = 0; r.rise = 0;
        for (int g = 0; g < t.per; g++) begin
            SYNC_IN = !(g >= SS && g < SS + t.wid);
            RSTN    = !(t.rst_at != 0 && g == t.rst_at);
            @(negedge CLK);
            if (int'(CNT) != g) r.mis++;
            r.stb += int'(LINE_STB);
            r.err += int'(ERR);
            if (LOCKED && !lock_q && r.rise == 0) r.rise = g;
            lock_q = LOCKED;
            if (t.rst_at != 0 && g == t.rst_at + 1) begin
                chk($sformatf("line%0d_rst_cnt", idx), int'(CNT), 0);
                chk($sformatf("line%0d_rst_locked", idx), int'(LOCKED), 0);
                chk($sformatf("line%0d_rst_period", idx), int'(PERIOD), 0);
                chk($sformatf("line%0d_rst_stb", idx), int'(LINE_STB), 0);
                chk($sformatf("line%0d_rst_err", idx), int'(ERR), 0);
            end
            @(posedge CLK);
            #1;
        end
        r.lock_end = int'(lock_q);
        r.period   = int'(PERIOD);
    endtask

    initial begin
        line_t e;
        res_t  r;

        //  per   wid  rst  stb err lock rise  match period
        add(1090, 113, 0,   1,  0,  0,   0,    1,    0);     // first edge: SEARCH -> ACQUIRE
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  1,   RISE, 1,    1090);  // third good verdict
        for (int i = 0; i < 6; i++)
            add(1090, 113, 0, 1, 0, 1, 0, 1, 1090);
        add(1095, 113, 0,   1,  0,  1,   0,    0,    1090);  // long line
        add(1090, 113, 0,   0,  1,  1,   0,    0,    0);     // timeout, late edge ignored
        add(1090, 113, 0,   1,  0,  1,   0,    0,    1090);  // realign
        add(1090, 113, 0,   1,  0,  1,   0,    1,    1090);
        add(1090, 120, 0,   1,  1,  1,   0,    1,    1090);  // bad width while locked
        add(1090, 113, 0,   1,  0,  1,   0,    1,    1090);  // clears miss counter
        add(1090, 0,   0,   0,  1,  1,   0,    1,    1090);  // sync held high
        add(1090, 0,   0,   0,  1,  0,   0,    1,    1090);
        add(1090, 0,   0,   0,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  0,   0,    1,    0);
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  2,   -1,   1,    1090);
        add(1090, 113, 0,   1,  0,  1,   -1,   1,    1090);
        add(1090, 113, 0,   1,  0,  1,   0,    1,    1090);
        add(1090, 113, 500, 1,  0,  0,   0,    0,    0);     // mid-line reset
        add(1090, 113, 0,   1,  0,  0,   0,    0,    0);
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 120, 0,   1,  0,  0,   0,    1,    1090);  // bad width in ACQUIRE
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  0,   0,    1,    1090);
        add(1090, 113, 0,   1,  0,  1,   RISE, 1,    1090);
        add(1090, 113, 0,   1,  0,  1,   0,    1,    1090);

        RSTN    = 1'b0;
        SYNC_IN = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_cnt", int'(CNT), 0);
        chk("reset_locked", int'(LOCKED), 0);
        chk("reset_line_stb", int'(LINE_STB), 0);
        chk("reset_period", int'(PERIOD), 0);
        chk("reset_err", int'(ERR), 0);
        @(posedge CLK);
        #1;

        foreach (tbl[i]) begin
            exp_q.push_back(tbl[i]);
            run_line(tbl[i], i + 1, r);
            e = exp_q.pop_front();
            chk($sformatf("line%0d_stb", i + 1), r.stb, e.stb);
            chk($sformatf("line%0d_err", i + 1), r.err, e.err);
            if (e.lock_end != 2) chk($sformatf("line%0d_locked", i + 1), r.lock_end, e.lock_end);
            if (e.rise >= 0) chk($sformatf("line%0d_lock_rise", i + 1), r.rise, e.rise);
            if (e.match != 0) chk($sformatf("line%0d_cnt_track", i + 1), r.mis, 0);
            if (e.period != 0) chk($sformatf("line%0d_period", i + 1), r.period, e.period);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: actual timeout required completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
